// File: rtl/usb_in_pkt_fifo.sv
// Packet-aware USB full-speed IN endpoint FIFO with retry-until-ACK and MPS packet splitting.
// Optional zero-length-packet termination of max-size transfers: define USB_IN_ZLP_EN.
module usb_in_pkt_fifo #(
  parameter int IN_MAXPACKETSIZE = 8,
  parameter int DEPTH            = 64,
  localparam int AW              = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          clk_gate_i,
  input  logic [7:0]    app_in_data_i,
  input  logic          app_in_last_i,
  input  logic          app_in_valid_i,
  output logic          app_in_ready_o,
  output logic [AW:0]   app_in_free_o,
  output logic [7:0]    in_data_o,
  output logic          in_valid_o,
  input  logic          in_req_i,
  input  logic          in_ready_i,
  input  logic          in_data_ack_i,
  output logic          in_empty_o,
  output logic          in_full_o
);

  localparam int CW = $clog2(IN_MAXPACKETSIZE + 1);
  localparam logic [AW:0]   DEPTH_V = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] MPS_V   = CW'(IN_MAXPACKETSIZE);

  // Application side: a byte moves on app_in_valid_i & app_in_ready_o at any clk_i edge;
  // SIE side: events count only on clk_gate_i & in_ready_i, and a byte is consumed only
  // while in_valid_o is high.

  logic [8:0]    mem [DEPTH];
  logic [AW:0]   wr_q;
  logic [AW:0]   ack_q;
  logic [AW:0]   rd_q;
  logic [AW:0]   used;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          zlp_q;
  logic          wr_en;
  logic          sie_ev;
  logic          send_ok;

  assign used           = wr_q - ack_q;
  assign in_full_o      = (used == DEPTH_V);
  assign app_in_ready_o = ~in_full_o;
  assign app_in_free_o  = DEPTH_V - used;
  assign in_empty_o     = (wr_q == ack_q) & ~zlp_q;
  assign send_ok        = (rd_q != wr_q) & (cnt_q < MPS_V) & ~done_q & ~zlp_q;
  assign in_valid_o     = send_ok;
  assign in_data_o      = mem[rd_q[AW-1:0]][7:0];

  assign wr_en  = app_in_valid_i & ~in_full_o;
  assign sie_ev = clk_gate_i & in_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_q[AW-1:0]] <= {app_in_last_i, app_in_data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_q <= '0;
    end else if (wr_en) begin
      wr_q <= wr_q + 1'b1;
    end
  end

  // A token rewinds to the last acknowledged byte so an unacknowledged packet is resent.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_q   <= '0;
      ack_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (sie_ev) begin
      if (in_req_i) begin
        rd_q   <= ack_q;
        cnt_q  <= '0;
        done_q <= 1'b0;
      end else if (in_data_ack_i) begin
        ack_q  <= rd_q;
        cnt_q  <= '0;
        done_q <= 1'b0;
      end else if (send_ok) begin
        rd_q   <= rd_q + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
        done_q <= mem[rd_q[AW-1:0]][8];
      end
    end
  end

`ifdef USB_IN_ZLP_EN
  // A transfer ending exactly on a max-size packet needs an empty packet to terminate it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      zlp_q <= 1'b0;
    end else if (sie_ev && !in_req_i && in_data_ack_i) begin
      if ((cnt_q == MPS_V) && done_q) begin
        zlp_q <= 1'b1;
      end else if (cnt_q == '0) begin
        zlp_q <= 1'b0;
      end
    end
  end
`else
  assign zlp_q = 1'b0;
`endif

endmodule

// File: tb/tb_usb_in_pkt_fifo.sv
// Bench for usb_in_pkt_fifo: directed packet scenarios plus randomized traffic checked
// against a queue-level model of the stored, sent and acknowledged bytes.
module tb_usb_in_pkt_fifo;

  localparam int MPS   = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          clk_gate_i = 1'b0;
  logic [7:0]    app_in_data_i = '0;
  logic          app_in_last_i = 1'b0;
  logic          app_in_valid_i = 1'b0;
  logic          app_in_ready_o;
  logic [AW:0]   app_in_free_o;
  logic [7:0]    in_data_o;
  logic          in_valid_o;
  logic          in_req_i = 1'b0;
  logic          in_ready_i = 1'b0;
  logic          in_data_ack_i = 1'b0;
  logic          in_empty_o;
  logic          in_full_o;

  usb_in_pkt_fifo #(.IN_MAXPACKETSIZE(MPS), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .clk_gate_i     (clk_gate_i),
    .app_in_data_i  (app_in_data_i),
    .app_in_last_i  (app_in_last_i),
    .app_in_valid_i (app_in_valid_i),
    .app_in_ready_o (app_in_ready_o),
    .app_in_free_o  (app_in_free_o),
    .in_data_o      (in_data_o),
    .in_valid_o     (in_valid_o),
    .in_req_i       (in_req_i),
    .in_ready_i     (in_ready_i),
    .in_data_ack_i  (in_data_ack_i),
    .in_empty_o     (in_empty_o),
    .in_full_o      (in_full_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // model: bytes held from the acknowledged point on, and progress through them
  logic [8:0] stor_q[$];
  int         sent;
  int         cnt;
  bit         done;
  bit         zlp;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_valid();
    return (sent < stor_q.size()) && (cnt < MPS) && !done && !zlp;
  endfunction

  task automatic check_model();
    chk("ready", 32'(app_in_ready_o), 32'(stor_q.size() != DEPTH));
    chk("full",  32'(in_full_o),      32'(stor_q.size() == DEPTH));
    chk("free",  32'(app_in_free_o),  32'(DEPTH - stor_q.size()));
    chk("empty", 32'(in_empty_o),     32'(stor_q.size() == 0 && !zlp));
    chk("valid", 32'(in_valid_o),     32'(m_valid()));
    if (m_valid()) chk("data", 32'(in_data_o), 32'(stor_q[sent][7:0]));
  endtask

  task automatic model_clear();
    stor_q.delete();
    exp_q.delete();
    sent = 0;
    cnt  = 0;
    done = 0;
    zlp  = 0;
  endtask

  // One clk_i edge with the currently driven inputs; the model follows the same edge.
  task automatic step();
    bit         wr_acc;
    bit         ev;
    bit         v;
    logic [8:0] wv;
    wr_acc = app_in_valid_i && (stor_q.size() < DEPTH);
    wv     = {app_in_last_i, app_in_data_i};
    ev     = clk_gate_i && in_ready_i;
    v      = m_valid();
    @(posedge clk_i);
    #1;
    if (ev) begin
      if (in_req_i) begin
        sent = 0; cnt = 0; done = 0;
      end else if (in_data_ack_i) begin
`ifdef USB_IN_ZLP_EN
        if (cnt == MPS && done) zlp = 1;
        else if (cnt == 0) zlp = 0;
`endif
        repeat (sent) void'(stor_q.pop_front());
        sent = 0; cnt = 0; done = 0;
      end else if (v) begin
        done = stor_q[sent][8];
        sent++;
        cnt++;
      end
    end
    if (wr_acc) stor_q.push_back(wv);
    check_model();
  endtask

  // driver tasks
  task automatic do_reset();
    rstn_i = 1'b0;
    clk_gate_i = 0; in_ready_i = 0; in_req_i = 0; in_data_ack_i = 0; app_in_valid_i = 0;
    app_in_data_i = '0; app_in_last_i = 0;
    #3;
    model_clear();
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  task automatic wr(input logic [7:0] d, input logic last);
    app_in_data_i = d; app_in_last_i = last; app_in_valid_i = 1'b1;
    step();
    app_in_valid_i = 1'b0; app_in_last_i = 1'b0;
  endtask

  task automatic sie(input logic req, input logic ack);
    clk_gate_i = 1; in_ready_i = 1; in_req_i = req; in_data_ack_i = ack;
    step();
    clk_gate_i = 0; in_ready_i = 0; in_req_i = 0; in_data_ack_i = 0;
  endtask

  task automatic rd_exp(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk(tag, 32'(in_data_o), 32'(e));
    chk({tag, "_v"}, 32'(in_valid_o), 32'd1);
    sie(0, 0);
  endtask

  // token, consume while bytes are offered, optionally acknowledge; returns packet length
  task automatic send_pkt(input bit ack, output int len);
    sie(1, 0);
    len = 0;
    for (int i = 0; i <= MPS && in_valid_o; i++) begin
      sie(0, 0);
      len++;
    end
    if (ack) sie(0, 1);
  endtask

  task automatic drain();
    int len;
    for (int i = 0; i < 40 && (stor_q.size() != 0 || zlp); i++) send_pkt(1, len);
    chk("drain_empty", 32'(in_empty_o), 32'd1);
  endtask

  initial begin
    int len;
    int lens[$];

    // reset values
    do_reset();
    chk("rst_ready", 32'(app_in_ready_o), 32'd1);
    chk("rst_free",  32'(app_in_free_o),  32'd64);
    chk("rst_valid", 32'(in_valid_o),     32'd0);
    chk("rst_empty", 32'(in_empty_o),     32'd1);
    chk("rst_full",  32'(in_full_o),      32'd0);
    chk("rst_data",  32'(in_data_o),      32'h00);

    // short transfer ends on the last flag
    wr(8'hA0, 0); wr(8'hA1, 0); wr(8'hA2, 1);
    exp_q = '{8'hA0, 8'hA1, 8'hA2};
    sie(1, 0);
    for (int i = 0; i < 3; i++) rd_exp("short_rd");
    chk("short_end_valid", 32'(in_valid_o), 32'd0);
    sie(0, 0);
    chk("short_end_valid2", 32'(in_valid_o), 32'd0);
    sie(0, 1);
    chk("short_ack_empty", 32'(in_empty_o), 32'd1);
    chk("short_ack_free",  32'(app_in_free_o), 32'd64);

    // long transfer splits at MPS, retry resends, ACK advances
    for (int i = 0; i < 20; i++) wr(8'(i), 0);
    sie(1, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 8; i++) rd_exp("long_rd");
    chk("long_mps_valid", 32'(in_valid_o), 32'd0);
    sie(1, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 8; i++) rd_exp("retry_rd");
    sie(0, 1);
    chk("long_ack_free", 32'(app_in_free_o), 32'd52);
    sie(1, 0);
    for (int i = 8; i < 16; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 8; i++) rd_exp("next_rd");
    sie(0, 1);
    send_pkt(1, len);
    chk("underrun_len", 32'(len), 32'd4);
    chk("long_empty", 32'(in_empty_o), 32'd1);

    // full, free only by ACK, retry keeps space occupied
    for (int i = 0; i < 64; i++) wr(8'(i + 8'h40), 0);
    chk("fill_ready", 32'(app_in_ready_o), 32'd0);
    chk("fill_full",  32'(in_full_o),      32'd1);
    chk("fill_free",  32'(app_in_free_o),  32'd0);
    wr(8'hEE, 0);
    chk("fill_reject_free", 32'(app_in_free_o), 32'd0);
    send_pkt(1, len);
    chk("fill_ack_ready", 32'(app_in_ready_o), 32'd1);
    chk("fill_ack_free",  32'(app_in_free_o),  32'd8);
    for (int i = 0; i < 8; i++) wr(8'(i + 8'hC0), 0);
    send_pkt(0, len);
    sie(1, 0);
    chk("retry_free", 32'(app_in_free_o), 32'd0);

    // write at full coincides with an ACK: blocked this cycle, accepted next
    for (int i = 0; i < 8; i++) sie(0, 0);
    app_in_valid_i = 1; app_in_data_i = 8'h77; app_in_last_i = 0;
    clk_gate_i = 1; in_ready_i = 1; in_data_ack_i = 1;
    step();
    clk_gate_i = 0; in_ready_i = 0; in_data_ack_i = 0;
    chk("same_cycle_free", 32'(app_in_free_o), 32'd8);
    step();
    app_in_valid_i = 0;
    chk("next_cycle_free", 32'(app_in_free_o), 32'd7);
    drain();

    // max-size packet ending a transfer, followed by another transfer
    do_reset();
    for (int i = 0; i < 8; i++) wr(8'(i + 8'h10), i == 7);
    wr(8'h55, 0); wr(8'h66, 1);
    for (int i = 0; i < 6 && !in_empty_o; i++) begin
      send_pkt(1, len);
      lens.push_back(len);
    end
`ifdef USB_IN_ZLP_EN
    chk("zlp_npkts", 32'(lens.size()), 32'd3);
    if (lens.size() == 3) begin
      chk("zlp_len0", 32'(lens[0]), 32'd8);
      chk("zlp_len1", 32'(lens[1]), 32'd0);
      chk("zlp_len2", 32'(lens[2]), 32'd2);
    end
`else
    chk("nozlp_npkts", 32'(lens.size()), 32'd2);
    if (lens.size() == 2) begin
      chk("nozlp_len0", 32'(lens[0]), 32'd8);
      chk("nozlp_len1", 32'(lens[1]), 32'd2);
    end
`endif

    // reset in the middle of a packet discards everything
    for (int i = 0; i < 12; i++) wr(8'(i + 1), i == 11);
    sie(1, 0); sie(0, 0); sie(0, 0);
    do_reset();
    chk("midrst_empty", 32'(in_empty_o),    32'd1);
    chk("midrst_free",  32'(app_in_free_o), 32'd64);
    chk("midrst_valid", 32'(in_valid_o),    32'd0);
    chk("midrst_data",  32'(in_data_o),     32'h00);

    // randomized traffic, including strobes without the gate
    for (int n = 0; n < 3000; n++) begin
      int r;
      app_in_valid_i = ($urandom_range(0, 99) < 50);
      app_in_data_i  = 8'($urandom);
      app_in_last_i  = ($urandom_range(0, 9) == 0);
      clk_gate_i     = ($urandom_range(0, 2) == 0);
      in_ready_i     = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 19);
      in_req_i       = (r == 0);
      in_data_ack_i  = (r == 1 || r == 2);
      step();
      app_in_valid_i = 0; clk_gate_i = 0; in_ready_i = 0; in_req_i = 0; in_data_ack_i = 0;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
